// File: rtl/sl_pkg.sv
// Shared SL line definitions: transmitter state encoding, line symbols and config bit positions.
// Reused by both the SL transmitter and the SL receiver.
package sl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StDend,
        StPar,
        StPend,
        StStop,
        StSend,
        StGap
    } sl_tx_state_t;

    // Line symbols as {sl0, sl1}
    localparam logic [1:0] SL_LINE_IDLE = 2'b11;
    localparam logic [1:0] SL_LINE_ONE  = 2'b10;
    localparam logic [1:0] SL_LINE_ZERO = 2'b01;
    localparam logic [1:0] SL_LINE_STOP = 2'b00;

    // Field positions inside the register-block config word
    localparam int unsigned SL_CFG_PAR_EN_BIT  = 0;
    localparam int unsigned SL_CFG_PAR_ODD_BIT = 1;
    localparam int unsigned SL_CFG_BITS_LSB    = 8;
    localparam int unsigned SL_CFG_DIV_LSB     = 16;
    localparam int unsigned SL_CFG_GAP_LSB     = 24;

    function automatic logic [1:0] sl_bit_enc(input logic b);
        return b ? SL_LINE_ONE : SL_LINE_ZERO;
    endfunction

endpackage

// File: rtl/sl_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sl_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      level_q <= level_q + LW'(1);
            else if (do_pop && !do_push) level_q <= level_q - LW'(1);
        end
    end

endmodule

// File: rtl/sl_tx_fifo.sv
// Buffered SL two-wire transmitter: FIFO of words serialised with per-word latched framing config.
// Line outputs are registered from the current state, so they trail the FSM by one cycle.
module sl_tx_fifo
    import sl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned GAP_W      = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [$clog2(DATA_W+1)-1:0]        cfg_bits,
    input  logic [DIV_W-1:0]                   cfg_div,
    input  logic                               cfg_par_en,
    input  logic                               cfg_par_odd,
    input  logic [GAP_W-1:0]                   cfg_gap,
    output logic                               sl0,
    output logic                               sl1,
    output logic                               busy,
    output logic                               word_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    sl_tx_state_t      state_q, state_d;
    logic [DIV_W-1:0]  phase_q, phase_d, div_q, div_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d, bits_q, bits_d, bits_clamped;
    logic [GAP_W-1:0]  gapcnt_q, gapcnt_d, gap_q, gap_d;
    logic [DATA_W-1:0] shift_q, shift_d, fifo_rd;
    logic              acc_q, acc_d, par_q, par_d, odd_q, odd_d;
    logic [1:0]        line_q, line_d;
    logic              done_q, done_d;
    logic              fifo_full, fifo_empty, pop, phase_end;
    logic [BW:0]       bit_nxt;
    logic [GAP_W:0]    gap_nxt;

    assign pop       = (state_q == StIdle) && !fifo_empty;
    assign wr_ready  = !fifo_full;
    assign busy      = (state_q != StIdle) || pop;
    assign sl0       = line_q[1];
    assign sl1       = line_q[0];
    assign word_done = done_q;
    assign phase_end = (phase_q == div_q);
    assign bit_nxt   = {1'b0, bitcnt_q} + (BW + 1)'(1);
    assign gap_nxt   = {1'b0, gapcnt_q} + (GAP_W + 1)'(1);

    assign bits_clamped = (cfg_bits == '0)         ? BW'(1) :
                          (cfg_bits > BW'(DATA_W)) ? BW'(DATA_W) : cfg_bits;

    sl_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_valid),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        bits_d   = bits_q;
        div_d    = div_q;
        par_d    = par_q;
        odd_d    = odd_q;
        gap_d    = gap_q;
        line_d   = SL_LINE_IDLE;
        done_d   = 1'b0;

        if (state_q != StIdle) begin
            phase_d = phase_end ? '0 : phase_q + DIV_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (!fifo_empty) begin
                    shift_d  = fifo_rd;
                    bitcnt_d = '0;
                    gapcnt_d = '0;
                    acc_d    = 1'b0;
                    bits_d   = bits_clamped;
                    div_d    = cfg_div;
                    par_d    = cfg_par_en;
                    odd_d    = cfg_par_odd;
                    gap_d    = cfg_gap;
                    state_d  = StData;
                end
            end
            StData: begin
                line_d = sl_bit_enc(shift_q[0]);
                if (phase_end) begin
                    acc_d   = acc_q ^ shift_q[0];
                    state_d = StDend;
                end
            end
            StDend: begin
                if (phase_end) begin
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bit_nxt[BW-1:0];
                    if (bit_nxt < {1'b0, bits_q}) state_d = StData;
                    else if (par_q)               state_d = StPar;
                    else                          state_d = StStop;
                end
            end
            StPar: begin
                line_d = sl_bit_enc(acc_q ^ odd_q);
                if (phase_end) state_d = StPend;
            end
            StPend: begin
                if (phase_end) state_d = StStop;
            end
            StStop: begin
                line_d = SL_LINE_STOP;
                if (phase_end) state_d = StSend;
            end
            StSend: begin
                if (phase_end) begin
                    done_d  = 1'b1;
                    state_d = (gap_q != '0) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (phase_end) begin
                    if (gap_nxt == {1'b0, gap_q}) state_d = StIdle;
                    else                          gapcnt_d = gap_nxt[GAP_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            shift_q  <= '0;
            acc_q    <= 1'b0;
            bits_q   <= BW'(1);
            div_q    <= '0;
            par_q    <= 1'b0;
            odd_q    <= 1'b0;
            gap_q    <= '0;
            line_q   <= SL_LINE_IDLE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            bits_q   <= bits_d;
            div_q    <= div_d;
            par_q    <= par_d;
            odd_q    <= odd_d;
            gap_q    <= gap_d;
            line_q   <= line_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_sl_tx_fifo.sv
// Bench for sl_tx_fifo: directed and random words against a per-word symbol-list reference model.
module tb_sl_tx_fifo;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 8;
    localparam int GAP_W      = 4;
    localparam int BW         = $clog2(DATA_W + 1);
    localparam int LW         = $clog2(FIFO_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [BW-1:0]     cfg_bits = BW'(8);
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_par_en = 1'b0;
    logic              cfg_par_odd = 1'b0;
    logic [GAP_W-1:0]  cfg_gap = '0;
    logic              sl0, sl1, busy, word_done;
    logic [LW-1:0]     fifo_level;

    sl_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W),
        .GAP_W      (GAP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .cfg_bits    (cfg_bits),
        .cfg_div     (cfg_div),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_gap     (cfg_gap),
        .sl0         (sl0),
        .sl1         (sl1),
        .busy        (busy),
        .word_done   (word_done),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queued words, and the per-cycle symbols {done, line} of the word in flight
    logic [DATA_W-1:0] mfifo[$];
    logic [2:0]        sq[$];
    logic [1:0]        exp_line = 2'b11;
    logic              exp_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    task automatic add(input logic [2:0] e, input int n);
        repeat (n) sq.push_back(e);
    endtask

    // A word is N (bit, rest) phase pairs, optional (parity, rest), stop, ending, then gap phases
    task automatic build(input logic [DATA_W-1:0] w);
        int n = int'(cfg_bits);
        int d = int'(cfg_div) + 1;
        int ones = 0;
        if (n == 0) n = 1;
        if (n > DATA_W) n = DATA_W;
        for (int i = 0; i < n; i++) begin
            add({1'b0, enc(w[i])}, d);
            add(3'b011, d);
            ones += int'(w[i]);
        end
        if (cfg_par_en) begin
            add({1'b0, enc(1'(ones % 2) ^ cfg_par_odd)}, d);
            add(3'b011, d);
        end
        add(3'b000, d);
        add(3'b011, d - 1);
        add(3'b111, 1);
        add(3'b011, int'(cfg_gap) * d);
    endtask

    // Advance model by one edge using the inputs now applied, then clock and compare
    task automatic step();
        logic [2:0] e;
        int lvl_pre;
        e = 3'b011;
        lvl_pre = mfifo.size();
        if (rst_n) begin
            if (sq.size() != 0) e = sq.pop_front();
            else if (mfifo.size() != 0) build(mfifo.pop_front());
            if (wr_valid && lvl_pre < FIFO_DEPTH) mfifo.push_back(wr_data);
        end
        exp_line = e[1:0];
        exp_done = e[2];
        @(posedge clk);
        #1;
        check("sl", {sl0, sl1}, exp_line);
        check("word_done", word_done, exp_done);
        check("busy", busy, (sq.size() != 0) || (mfifo.size() != 0));
        check("fifo_level", fifo_level, mfifo.size());
        check("wr_ready", wr_ready, mfifo.size() != FIFO_DEPTH);
    endtask

    task automatic push_wait(input logic [DATA_W-1:0] w);
        bit acc;
        int guard = 0;
        wr_data  = w;
        wr_valid = 1'b1;
        do begin
            acc = (mfifo.size() < FIFO_DEPTH);
            step();
            guard++;
        end while (!acc && guard < 2000);
        wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget = 5000;
        while ((sq.size() != 0 || mfifo.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        step();
        check(tag, {busy, sl0, sl1}, 3'b011);
    endtask

    task automatic set_cfg(input int bits, input int div, input bit pen, input bit odd,
                           input int gap);
        cfg_bits    = BW'(bits);
        cfg_div     = DIV_W'(div);
        cfg_par_en  = pen;
        cfg_par_odd = odd;
        cfg_gap     = GAP_W'(gap);
    endtask

    initial begin
        int n;
        int m;

        // Reset values
        repeat (2) step();
        check("rst_line", {sl0, sl1}, 2'b11);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Single word 0xA5, odd parity, 2-cycle phases
        set_cfg(8, 1, 1'b1, 1'b1, 0);
        push_wait(32'hA5);
        n = 0;
        do begin
            step();
            n++;
        end while ({sl0, sl1} == 2'b11 && n < 10);
        check("first_data_latency", n, 2);
        check("a5_bit0", {sl0, sl1}, 2'b10);
        m = 1;
        while (!word_done && m < 200) begin
            step();
            m++;
        end
        check("a5_word_cycles", m, 40);
        drain("a5_idle");

        // Even parity, then no parity
        set_cfg(3, 1, 1'b1, 1'b0, 0);
        push_wait(32'h7);
        drain("even_idle");
        set_cfg(3, 1, 1'b0, 1'b0, 0);
        push_wait(32'h7);
        drain("nopar_idle");

        // Back-to-back with FIFO overflow attempt
        set_cfg(4, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            push_wait(32'h10 + i);
            if (i == 4) check("full_ready", wr_ready, 1'b0);
        end
        drain("b2b_idle");

        // Config change during word 1 applies to word 2 only
        set_cfg(8, 1, 1'b0, 1'b0, 0);
        push_wait(32'h3C);
        push_wait(32'hC3);
        repeat (5) step();
        set_cfg(4, 3, 1'b0, 1'b0, 0);
        drain("cfgchg_idle");

        // Boundaries: N=0, N>DATA_W, gap=3, div=0
        set_cfg(0, 0, 1'b0, 1'b0, 0);
        push_wait(32'h1);
        drain("n0_idle");
        set_cfg(DATA_W + 5, 0, 1'b1, 1'b0, 0);
        push_wait(32'hDEADBEEF);
        drain("nmax_idle");
        set_cfg(2, 1, 1'b0, 1'b0, 3);
        push_wait(32'h2);
        push_wait(32'h1);
        drain("gap_idle");

        // Asynchronous reset during DATA
        set_cfg(8, 3, 1'b0, 1'b0, 0);
        push_wait(32'hFF);
        repeat (3) step();
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_line", {sl0, sl1}, 2'b11);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_level", fifo_level, 0);
        check("async_rst_done", word_done, 1'b0);
        sq.delete();
        mfifo.delete();
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Random traffic with config changes at arbitrary times
        for (int c = 0; c < 2500; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = DATA_W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                set_cfg($urandom_range(0, DATA_W + 6), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3));
            end
            step();
        end
        wr_valid = 1'b0;
        drain("rand_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
